// File: rtl/nested_index_counter.sv
// Chained multi-level loop index counter (level 0 innermost) with programmable
// per-level limits, carry ripple, per-level wrap pulses and a sticky done flag.
module nested_index_counter #(
  parameter int word_size = 16,
  parameter int levels    = 3,
  parameter int sel_width = 2,
  parameter int increment = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_en,
  input  logic                        limit_we,
  input  logic [sel_width-1:0]        sel,
  input  logic [word_size-1:0]        data_in,
  input  logic                        inc,
  input  logic                        clr,
  output logic [levels*word_size-1:0] data_out,
  output logic [levels-1:0]           wrap,
  output logic                        done
);

  localparam logic [word_size:0] inner_step = (word_size+1)'(increment);
  localparam logic [word_size:0] outer_step = (word_size+1)'(1);

  logic [word_size-1:0] count     [levels];
  logic [word_size-1:0] limit     [levels];
  logic [word_size-1:0] count_nxt [levels];
  logic [word_size:0]   res       [levels];
  logic [levels-1:0]    carry;
  logic                 ripple;
  logic                 sel_valid;

  // One level's step: {carry, next}. The extra bit keeps full-scale overflow
  // visible, and a count already above its limit also wraps to zero.
  function automatic logic [word_size:0] step_level(
    input logic [word_size-1:0] cnt,
    input logic [word_size:0]   step,
    input logic [word_size-1:0] lim
  );
    logic [word_size:0] cand;
    cand = {1'b0, cnt} + step;
    if (cand > {1'b0, lim})
      return {1'b1, {word_size{1'b0}}};
    return cand;
  endfunction

  assign sel_valid = (int'(sel) < levels);

  always_comb begin
    carry  = '0;
    ripple = 1'b1;
    for (int l = 0; l < levels; l++) begin
      res[l]       = step_level(count[l], (l == 0) ? inner_step : outer_step, limit[l]);
      count_nxt[l] = count[l];
      if (ripple) begin
        count_nxt[l] = res[l][word_size-1:0];
        carry[l]     = res[l][word_size];
      end
      ripple = carry[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < levels; l++) begin
        count[l] <= '0;
        limit[l] <= '1;
      end
      wrap <= '0;
      done <= 1'b0;
    end else if (clr) begin
      for (int l = 0; l < levels; l++)
        count[l] <= '0;
      wrap <= '0;
      done <= 1'b0;
    end else if (inc) begin
      for (int l = 0; l < levels; l++)
        count[l] <= count_nxt[l];
      wrap <= carry;
      if (carry[levels-1])
        done <= 1'b1;
    end else begin
      wrap <= '0;
      if (write_en && sel_valid) begin
        count[sel] <= data_in;
        done       <= 1'b0;
      end
      if (limit_we && sel_valid)
        limit[sel] <= data_in;
    end
  end

  for (genvar g = 0; g < levels; g++) begin : g_out
    assign data_out[g*word_size +: word_size] = count[g];
  end

endmodule

// File: doc/nested_index_counter.md
# nested_index_counter

Parametrised multi-level index counter for the matrix-multiplication datapath. It generates nested loop indices (i/j/k) for operand and result addressing. It supersedes the single load/increment register with per-level programmable limits, wrap-with-carry chaining, a configurable innermost step, per-level wrap pulses and a completion flag. After reset it behaves as a plain free-running incrementing register on level 0.

## Interface

- word_size, 16, width of each level's count and limit
- levels, 3, number of chained levels; level 0 is innermost
- sel_width, 2, width of sel; must satisfy 2^sel_width >= levels
- increment, 1, step added to level 0 per inc; outer levels always step by 1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- write_en  in  1  load data_in into count[sel]
- limit_we  in  1  load data_in into limit[sel]
- sel  in  sel_width  level selected by write_en and limit_we
- data_in  in  word_size  load data
- inc  in  1  advance the counter chain by one step
- clr  in  1  synchronous clear of all counts; limits are kept
- data_out  out  levels*word_size  all counts; level l at bits [l*word_size +: word_size]
- wrap  out  levels  wrap[l] pulses for one cycle when level l wrapped on the last update
- done  out  1  sticky; set when the outermost level wraps

## Operation

- Reset (rst=0, asynchronous): every count is 0, wrap is 0, done is 0, every limit is all-ones.
- Each level counts 0..limit[l] inclusive.
- Priority on each rising edge: clr > inc > (write_en / limit_we).
- clr: all counts go to 0, wrap goes to 0, done goes to 0.
- inc: ripple update computed combinationally within one cycle.
  - Level 0 candidate = count[0] + increment, computed in word_size+1 bits.
  - If candidate > limit[0], count[0] goes to 0 and carry[0]=1; otherwise count[0] takes the candidate.
  - Level l>0: if carry[l-1]=1, apply the same rule with step 1 and produce carry[l]; otherwise hold and carry[l]=0.
  - wrap takes carry[levels-1:0].
  - If carry[levels-1]=1, done sets to 1; otherwise done holds.
- write_en (without clr or inc): count[sel] takes data_in, done clears to 0, wrap goes to 0.
- limit_we (without clr or inc): limit[sel] takes data_in. This may coincide with write_en on the same edge; both registers load.
- sel >= levels: write_en and limit_we have no effect.
- When no command is active, counts, limits and done hold, and wrap goes to 0.
- Out-of-range count: if count[l] > limit[l] (lowered limit or over-range load), the next step into that level wraps it to 0 with carry.
- A limit of 0 makes that level wrap on every step it receives.
- Full-scale arithmetic: limit all-ones with count + increment overflowing word_size bits is detected through the extra bit. It wraps to 0 with carry and never truncates silently.

## Timing

- All outputs are registered.
- data_out, wrap and done reflect a command on the first rising edge after the command is sampled; latency is 1 cycle.
- wrap is exactly one cycle wide per wrapping step. Back-to-back inc can give back-to-back wrap pulses.
- inc is accepted every cycle with no stall and no handshake.
- Reset asserted mid-sequence clears state immediately, without waiting for clk.
- Reset deassertion is synchronised externally. The first edge after release may already act on inputs.
- The full carry ripple through all levels completes within the single cycle.

## Test plan

- Reset, then 5× inc with default limits → level 0 reads 1,2,3,4,5; levels 1 and 2 stay 0; wrap=0; done=0.
- Limits 2/1/1 via limit_we, then 12× inc:
  - Sequence ends at all-zero counts.
  - wrap[0] pulses on inc 3,6,9,12.
  - wrap[1] pulses on inc 6,12.
  - wrap[2] and done set on inc 12.
- increment=4, limit[0]=10, 3× inc → count[0] reads 4,8,0; wrap[0] pulses on the third inc; level 1 reads 1.
- inc and write_en in the same cycle → only the inc takes effect. clr asserted alongside inc → all counts 0 and done=0.
- write_en with sel=1, data_in=7, limit[1]=3, then drive level 1 via wraps of level 0 → level 1 returns to 0 with wrap[1]. Then write_en with sel=3 → no state change.
- rst pulsed low mid-count (not aligned to clk) → all counts 0 and done=0 immediately; limits return to all-ones.
